// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART transmit path:
//   - UART_DATA_W        : width of one serialized byte
//   - *_BIT              : bit positions of the arbiter's one-hot states
//   - ctrl_states_t      : one-hot state encoding of the arbiter FSM
//   - uart_tx_state_t    : state encoding of the uart_tx serializer
//   - max_int()          : elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Bit position of each arbiter state inside the one-hot state vector.
  localparam int IDLE_BIT = 0;
  localparam int SEND_BIT = 1;
  localparam int WAIT_BIT = 2;
  localparam int GAP_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001 << IDLE_BIT,
    ST_SEND = 4'b0001 << SEND_BIT,
    ST_WAIT = 4'b0001 << WAIT_BIT,
    ST_GAP  = 4'b0001 << GAP_BIT
  } ctrl_states_t;

  // Serializer states, kept here so uart_tx and its users agree on them.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  // Larger of two integers; used to size the shared WAIT/GAP counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// ---------------------------------------------------------------------------
// uart_rr_picker
// Combinational rotate-priority encoder. The search starts at last+1 and
// wraps modulo NUM_REQ, so the most recently served requester has the lowest
// priority.
// Ports:
//   req    in  NUM_REQ  request levels
//   last   in  IDX_W    index of the requester served last
//   valid  out 1        at least one request is pending
//   winner out IDX_W    index of the selected requester (0 when !valid)
// ---------------------------------------------------------------------------
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  // Walk the requesters in rotated order; the first set bit is latched and
  // later hits cannot overwrite it because valid is already high.
  always_comb begin
    logic [IDX_W-1:0] idx_s;
    valid  = 1'b0;
    winner = '0;
    idx_s  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_s  = IDX_W'((int'(last) + off) % NUM_REQ);
      winner = (!valid && req[idx_s]) ? idx_s : winner;
      valid  = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx serializer between NUM_REQ byte producers. One requester
// is granted per frame in round-robin order; the block then waits for the
// serializer's tx_done, optionally idles GAP_CYCLES clocks, and arbitrates
// again. A watchdog aborts a frame that never completes and raises a sticky
// error flag.
// Ports:
//   clk       in  1               rising-edge clock
//   rst       in  1               asynchronous reset, active low
//   req       in  NUM_REQ         per-requester request level
//   req_data  in  NUM_REQ*8       byte of requester i at [8i+7:8i]
//   gnt       out NUM_REQ         one-hot pulse: requester's byte accepted
//   done      out NUM_REQ         one-hot pulse: requester's frame finished
//   tx_send   out 1               start pulse to uart_tx
//   tx_data   out 8               byte to uart_tx, valid with tx_send
//   tx_done   in  1               end-of-frame pulse from uart_tx
//   busy      out 1               arbiter not idle
//   err       out 1               sticky watchdog timeout flag
//   err_clr   in  1               clears err (a same-cycle timeout wins)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           tx_send,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_done,
  output logic                           busy,
  output logic                           err,
  input  logic                           err_clr
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = max_int(TIMEOUT_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] REQ_ONE      = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_RST     = IDX_W'(NUM_REQ - 1);
  // Where a finished or aborted frame goes; GAP is skipped entirely at 0.
  localparam ctrl_states_t       WAIT_EXIT    = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  // Registered state and outputs
  ctrl_states_t             state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [IDX_W-1:0]         owner_r;
  logic [IDX_W-1:0]         last_r;
  logic [UART_DATA_W-1:0]   tx_data_r;
  logic [NUM_REQ-1:0]       gnt_r;
  logic [NUM_REQ-1:0]       done_r;
  logic                     tx_send_r;
  logic                     busy_r;
  logic                     err_r;

  // Next-state values
  ctrl_states_t             state_nx_s;
  logic [CNT_W-1:0]         cnt_nx_s;
  logic [IDX_W-1:0]         owner_nx_s;
  logic [IDX_W-1:0]         last_nx_s;
  logic [UART_DATA_W-1:0]   tx_data_nx_s;
  logic [NUM_REQ-1:0]       gnt_nx_s;
  logic [NUM_REQ-1:0]       done_nx_s;
  logic                     tx_send_nx_s;
  logic                     err_nx_s;

  logic [CNT_W-1:0]         cnt_inc_s;
  logic                     pick_valid_s;
  logic [IDX_W-1:0]         pick_winner_s;
  logic [UART_DATA_W-1:0]   req_bytes_s [NUM_REQ];

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .last   (last_r),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // Saturating increment: the shared counter must never wrap back to zero.
  assign cnt_inc_s = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);

  // Split the flat request bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes_s[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    owner_nx_s   = owner_r;
    last_nx_s    = last_r;
    tx_data_nx_s = tx_data_r;
    gnt_nx_s     = '0;
    done_nx_s    = '0;
    tx_send_nx_s = 1'b0;
    if (err_clr) begin
      err_nx_s = 1'b0;
    end else begin
      err_nx_s = err_r;
    end

    case (state_r)
      ST_IDLE: begin
        // gnt/tx_send are set on entry to SEND so they are visible during it.
        if (pick_valid_s) begin
          owner_nx_s   = pick_winner_s;
          last_nx_s    = pick_winner_s;
          tx_data_nx_s = req_bytes_s[pick_winner_s];
          gnt_nx_s     = REQ_ONE << pick_winner_s;
          tx_send_nx_s = 1'b1;
          state_nx_s   = ST_SEND;
        end else begin
          state_nx_s   = ST_IDLE;
        end
      end
      ST_SEND: begin
        cnt_nx_s   = '0;
        state_nx_s = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done is checked first so a completion in the last watchdog
        // cycle is a normal finish, not an error.
        if (tx_done) begin
          done_nx_s  = REQ_ONE << owner_r;
          cnt_nx_s   = '0;
          state_nx_s = WAIT_EXIT;
        end else if (cnt_r == TIMEOUT_LAST) begin
          err_nx_s   = 1'b1;
          done_nx_s  = REQ_ONE << owner_r;
          cnt_nx_s   = '0;
          state_nx_s = WAIT_EXIT;
        end else begin
          cnt_nx_s   = cnt_inc_s;
        end
      end
      ST_GAP: begin
        if (cnt_r >= GAP_LAST) begin
          cnt_nx_s   = '0;
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s   = cnt_inc_s;
        end
      end
      default: begin
        // Illegal one-hot pattern: recover to IDLE.
        cnt_nx_s   = '0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, arbitration history and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      owner_r   <= '0;
      last_r    <= LAST_RST;
      tx_data_r <= 8'h00;
      gnt_r     <= '0;
      done_r    <= '0;
      tx_send_r <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      owner_r   <= owner_nx_s;
      last_r    <= last_nx_s;
      tx_data_r <= tx_data_nx_s;
      gnt_r     <= gnt_nx_s;
      done_r    <= done_nx_s;
      tx_send_r <= tx_send_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
      err_r     <= err_nx_s;
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign tx_send = tx_send_r;
  assign tx_data = tx_data_r;
  assign busy    = busy_r;
  assign err     = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYCLES=2,
// TIMEOUT_CYCLES=16). The serializer is modelled by driving tx_done by hand.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_byte [4];

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polls for tx_send; n = ticks waited, ok = seen within the budget.
  task automatic wait_send(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      if (tx_send === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 4'b0000; tx_done = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0000; tx_done = 1'b0; err_clr = 1'b0;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b want 0010", gnt); end
    checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL single_tx_send: got %b want 1", tx_send); end
    checks++; if (tx_data !== 8'h48) begin errors++; $display("FAIL single_tx_data: got %h want 48", tx_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    req = 4'b0000;
    tick();
    checks++; if ({gnt, tx_send} !== 5'b00000) begin errors++; $display("FAIL single_pulse_len: got %b want 00000", {gnt, tx_send}); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL single_done: got %b want 0010", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy0: got %b want 1", busy); end
    tick();
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse: got %b want 0000", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy1: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    // tx_done while idle must be ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if ({done, busy} !== 5'b00000) begin errors++; $display("FAIL stray_tx_done: got %b want 00000", {done, busy}); end
  endtask

  task automatic test_fairness();
    int n;
    bit ok;
    int idx;
    int extra;
    do_reset();
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      idx = f % 4;
      wait_send(n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_send_timeout: frame %0d got no tx_send want one", f); end
      if (f > 0) begin
        checks++; if (n != 3) begin errors++; $display("FAIL fair_gap_latency: frame %0d got %0d want 3", f, n); end
      end
      checks++; if (gnt !== (4'b0001 << idx)) begin errors++; $display("FAIL fair_gnt: frame %0d got %b want %b", f, gnt, 4'b0001 << idx); end
      checks++; if (tx_data !== exp_byte[idx]) begin errors++; $display("FAIL fair_data: frame %0d got %h want %h", f, tx_data, exp_byte[idx]); end
      tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checks++; if (done !== (4'b0001 << idx)) begin errors++; $display("FAIL fair_done: frame %0d got %b want %b", f, done, 4'b0001 << idx); end
    end
    req = 4'b0000;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_send === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL fair_extra_send: got %0d want 0", extra); end
  endtask

  task automatic test_withdrawal();
    int n;
    bit ok;
    req = 4'b0001;
    wait_send(n, ok);
    checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL wd_first_gnt: got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
    req = 4'b1100;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wd_no_gnt: got %b want 0000", gnt); end
    req = 4'b1000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL wd_done0: got %b want 0001", done); end
    wait_send(n, ok);
    checks++; if (!ok || gnt !== 4'b1000) begin errors++; $display("FAIL wd_next_gnt: got %b want 1000", gnt); end
    checks++; if (tx_data !== 8'hD3) begin errors++; $display("FAIL wd_next_data: got %h want d3", tx_data); end
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL wd_done3: got %b want 1000", done); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    req = 4'b0100;
    wait_send(n, ok);
    checks++; if (!ok || gnt !== 4'b0100) begin errors++; $display("FAIL to_gnt: got %b want 0100", gnt); end
    req = 4'b0000;
    repeat (16) tick();
    checks++; if ({err, done, busy} !== 6'b000001) begin errors++; $display("FAIL to_early: got %b want 000001", {err, done, busy}); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL to_done: got %b want 0100", done); end
    req = 4'b0001;
    wait_send(n, ok);
    checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL to_next_gnt: got %b want 0001", gnt); end
    req = 4'b0000;
    repeat (16) tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err); end
    // clear request coincides with a fresh timeout: set wins
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b want 1", err); end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL to_done2: got %b want 0001", done); end
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_clr: got %b want 0", err); end
  endtask

  task automatic test_collision();
    int n;
    bit ok;
    req = 4'b0010;
    wait_send(n, ok);
    checks++; if (!ok || gnt !== 4'b0010) begin errors++; $display("FAIL col_gnt: got %b want 0010", gnt); end
    req = 4'b0000;
    repeat (16) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL col_err: got %b want 0", err); end
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL col_done: got %b want 0010", done); end
    tick();
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL col_done_once: got %b want 0000", done); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    req = 4'b1000;
    wait_send(n, ok);
    checks++; if (!ok || gnt !== 4'b1000) begin errors++; $display("FAIL rm_gnt: got %b want 1000", gnt); end
    req = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if ({gnt, done, tx_send} !== 9'b0) begin errors++; $display("FAIL rm_pulses: got %b want 000000000", {gnt, done, tx_send}); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rm_tx_data: got %h want 00", tx_data); end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if ({done, busy} !== 5'b00000) begin errors++; $display("FAIL rm_no_done: got %b want 00000", {done, busy}); end
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_first_gnt: got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL rm_done: got %b want 0001", done); end
    tick(); tick(); tick();
  endtask

  initial begin
    exp_byte[0] = 8'hA0;
    exp_byte[1] = 8'h48;
    exp_byte[2] = 8'hC2;
    exp_byte[3] = 8'hD3;
    req_data = {exp_byte[3], exp_byte[2], exp_byte[1], exp_byte[0]};
    test_reset();
    test_single();
    test_fairness();
    test_withdrawal();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
